// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared opcodes, FSM state encodings and datapath select codes
//               for the multi-cycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;

    // Controller states, exported on state_dbg
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // ALU operation select
    localparam logic [1:0] c_ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] c_ALU_OP_IMM   = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] c_ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] c_ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] c_ALUSRCB_IMMSH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Instruction classes used by DECODE to pick the execute path
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_IMM     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] op);
        classify = CLS_ILLEGAL;
        case (op)
            c_OP_RTYPE:                    classify = CLS_RTYPE;
            c_OP_LW, c_OP_SW:              classify = CLS_MEM;
            c_OP_BEQ, c_OP_BNE:            classify = CLS_BRANCH;
            c_OP_J:                        classify = CLS_JUMP;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI,
            c_OP_SLTI, c_OP_LUI:           classify = CLS_IMM;
            default:                       classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Dwell counter for memory-access states. Counts cycles since
//               entry, saturates at MEM_LAT-1, and flags completion when the
//               minimum dwell is met and memory is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    input  logic ready_i,
    output logic done_o
);

    localparam int             CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so the first cycle of every memory state sees zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != c_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = ready_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore-style main controller for the multi-cycle MIPS
//               datapath. Sequences FETCH/DECODE/EXECUTE/MEM/WB per opcode,
//               waits on shared memory, traps undefined opcodes and pulses
//               instr_retire in the last cycle of each instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,   // only the low six bits carry the MIPS opcode
    parameter int MEM_LAT  = 1,
    parameter bit TRAP_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                illegal_op,
    output logic                instr_retire,
    output logic [3:0]          state_dbg
);

    state_t    state_q;
    state_t    state_d;
    op_class_t w_cls;
    logic [5:0] w_op;
    logic      w_mem_state;
    logic      w_clear;
    logic      w_done;

    assign w_op        = opcode[5:0];
    assign w_cls       = classify(w_op);
    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Restart the dwell count on any state change so each memory state
    // starts from zero, including back-to-back memory states.
    assign w_clear     = !w_mem_state || (state_d != state_q);

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (w_clear),
        .enable_i (w_mem_state),
        .ready_i  (mem_ready),
        .done_o   (w_done)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = c_PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_ALUSRCB_REG;
        alu_op        = c_ALU_OP_ADD;
        illegal_op    = 1'b0;
        instr_retire  = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 computed every cycle; only committed with the fetch
                mem_read  = 1'b1;
                alu_src_b = c_ALUSRCB_FOUR;
                alu_op    = c_ALU_OP_ADD;
                pc_source = c_PCSRC_ALU;
                if (w_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                alu_src_b = c_ALUSRCB_IMMSH;
                alu_op    = c_ALU_OP_ADD;
                case (w_cls)
                    CLS_RTYPE:  state_d = S_EXEC;
                    CLS_MEM:    state_d = S_MEMADR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_IMM:    state_d = S_IMMEX;
                    default: begin
                        if (TRAP_EN) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d      = S_FETCH;
                            instr_retire = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_ALUSRCB_IMM;
                alu_op    = c_ALU_OP_ADD;
                state_d   = (w_op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (w_done) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg   = 1'b1;
                reg_write    = 1'b1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (w_done) begin
                    instr_retire = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_ALUSRCB_REG;
                alu_op    = c_ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst      = 1'b1;
                reg_write    = 1'b1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = c_ALUSRCB_IMM;
                alu_op    = (w_op == c_OP_ADDI) ? c_ALU_OP_ADD : c_ALU_OP_IMM;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write    = 1'b1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = c_ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = c_PCSRC_ALUOUT;
                branch_ne     = (w_op == c_OP_BNE);
                instr_retire  = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = c_PCSRC_JUMP;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                // Sticky until reset
                illegal_op = 1'b1;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Randomised self-checking bench. Two controllers are built:
//               index 0 with MEM_LAT=1/TRAP_EN=1, index 1 with MEM_LAT=3/
//               TRAP_EN=0. Each instruction is expanded into a list of
//               phases with expected controls, and memory phases end on the
//               first ready cycle once the minimum dwell has elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    // Control word layout:
    // {pc_write, pc_write_cond, branch_ne, pc_source[1:0], i_or_d, mem_read,
    //  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b[1:0], alu_op[1:0], illegal_op, instr_retire}
    localparam logic [18:0] c_PCW    = 19'd1 << 18;
    localparam logic [18:0] c_PWC    = 19'd1 << 17;
    localparam logic [18:0] c_BNE    = 19'd1 << 16;
    localparam logic [18:0] c_PCS_AO = 19'd1 << 14;
    localparam logic [18:0] c_PCS_J  = 19'd2 << 14;
    localparam logic [18:0] c_IORD   = 19'd1 << 13;
    localparam logic [18:0] c_MRD    = 19'd1 << 12;
    localparam logic [18:0] c_MWR    = 19'd1 << 11;
    localparam logic [18:0] c_IRW    = 19'd1 << 10;
    localparam logic [18:0] c_RDST   = 19'd1 << 9;
    localparam logic [18:0] c_M2R    = 19'd1 << 8;
    localparam logic [18:0] c_RW     = 19'd1 << 7;
    localparam logic [18:0] c_SRCA   = 19'd1 << 6;
    localparam logic [18:0] c_B_FOUR = 19'd1 << 4;
    localparam logic [18:0] c_B_IMM  = 19'd2 << 4;
    localparam logic [18:0] c_B_IMM2 = 19'd3 << 4;
    localparam logic [18:0] c_A_SUB  = 19'd1 << 2;
    localparam logic [18:0] c_A_FN   = 19'd2 << 2;
    localparam logic [18:0] c_A_IMM  = 19'd3 << 2;
    localparam logic [18:0] c_ILL    = 19'd1 << 1;
    localparam logic [18:0] c_RET    = 19'd1;
    localparam logic [3:0]  c_NOSTOP = 4'hF;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] base;
        logic [18:0] extra;   // added only in the cycle a memory phase completes
        bit          mem;
        int          reps;    // cycles spent in a non-memory phase
    } phase_t;

    logic        clk = 1'b0;
    logic        r_rstn [2];
    logic [5:0]  r_opc  [2];
    logic        r_rdy  [2];
    wire  [18:0] w_cw   [2];
    wire  [3:0]  w_st   [2];
    int          n_chk  = 0;
    int          n_fail = 0;
    phase_t      r_ph [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire       pcw, pwc, bne, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill, ret;
        wire [1:0] pcs, srcb, aop;
        multicycle_control_unit #(
            .OPCODE_W (6),
            .MEM_LAT  ((g == 0) ? 1 : 3),
            .TRAP_EN  ((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk           (clk),
            .rst_n         (r_rstn[g]),
            .opcode        (r_opc[g]),
            .mem_ready     (r_rdy[g]),
            .pc_write      (pcw),
            .pc_write_cond (pwc),
            .branch_ne     (bne),
            .pc_source     (pcs),
            .i_or_d        (iord),
            .mem_read      (mrd),
            .mem_write     (mwr),
            .ir_write      (irw),
            .reg_dst       (rdst),
            .mem_to_reg    (m2r),
            .reg_write     (rw),
            .alu_src_a     (srca),
            .alu_src_b     (srcb),
            .alu_op        (aop),
            .illegal_op    (ill),
            .instr_retire  (ret),
            .state_dbg     (w_st[g])
        );
        assign w_cw[g] = {pcw, pwc, bne, pcs, iord, mrd, mwr, irw, rdst, m2r, rw,
                          srca, srcb, aop, ill, ret};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic phase_t ph(input logic [3:0] st, input logic [18:0] b,
                                  input logic [18:0] e, input bit m, input int reps);
        phase_t p;
        p.st = st; p.base = b; p.extra = e; p.mem = m; p.reps = reps;
        return p;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                          6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
    endfunction

    function automatic logic [5:0] rand_legal();
        logic [5:0] tbl [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
        return tbl[$urandom_range(0, 10)];
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
        return op;
    endfunction

    // Expand one instruction into its sequence of phases
    task automatic build(input int idx, input logic [5:0] op);
        r_ph.delete();
        r_ph.push_back(ph(S_FETCH, c_MRD | c_B_FOUR, c_IRW | c_PCW, 1, 1));
        if (!is_legal(op) && idx == 1) begin
            r_ph.push_back(ph(S_DECODE, c_B_IMM2 | c_RET, 0, 0, 1));
            return;
        end
        r_ph.push_back(ph(S_DECODE, c_B_IMM2, 0, 0, 1));
        if (op == 6'h23) begin
            r_ph.push_back(ph(S_MEMADR, c_SRCA | c_B_IMM, 0, 0, 1));
            r_ph.push_back(ph(S_MEMRD,  c_MRD | c_IORD, 0, 1, 1));
            r_ph.push_back(ph(S_MEMWB,  c_M2R | c_RW | c_RET, 0, 0, 1));
        end else if (op == 6'h2B) begin
            r_ph.push_back(ph(S_MEMADR, c_SRCA | c_B_IMM, 0, 0, 1));
            r_ph.push_back(ph(S_MEMWR,  c_MWR | c_IORD, c_RET, 1, 1));
        end else if (op == 6'h00) begin
            r_ph.push_back(ph(S_EXEC,  c_SRCA | c_A_FN, 0, 0, 1));
            r_ph.push_back(ph(S_ALUWB, c_RDST | c_RW | c_RET, 0, 0, 1));
        end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F}) begin
            r_ph.push_back(ph(S_IMMEX, c_SRCA | c_B_IMM | ((op == 6'h08) ? 19'd0 : c_A_IMM), 0, 0, 1));
            r_ph.push_back(ph(S_IMMWB, c_RW | c_RET, 0, 0, 1));
        end else if (op inside {6'h04, 6'h05}) begin
            r_ph.push_back(ph(S_BRANCH, c_SRCA | c_A_SUB | c_PWC | c_PCS_AO | c_RET |
                                        ((op == 6'h05) ? c_BNE : 19'd0), 0, 0, 1));
        end else if (op == 6'h02) begin
            r_ph.push_back(ph(S_JUMP, c_PCW | c_PCS_J | c_RET, 0, 0, 1));
        end else begin
            r_ph.push_back(ph(S_TRAP, c_ILL, 0, 0, 20));
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready low for 5 cycles per memory phase
    task automatic run_instr(input int idx, input logic [5:0] op, input int rmode,
                             input logic [3:0] stop_st);
        int  lat;
        int  n;
        bit  d;
        bit  fin;
        bit  first;
        logic [18:0] exp;
        lat   = (idx == 0) ? 1 : 3;
        first = 1'b1;
        build(idx, op);
        foreach (r_ph[pi]) begin
            if (r_ph[pi].st == stop_st) return;
            n   = 0;
            fin = 1'b0;
            while (!fin) begin
                @(negedge clk);
                if (first) r_opc[idx] = op;
                first = 1'b0;
                n++;
                case (rmode)
                    0:       r_rdy[idx] = 1'b1;
                    1:       r_rdy[idx] = 1'($urandom_range(0, 1));
                    default: r_rdy[idx] = (n > 5);
                endcase
                if (n > lat + 8) r_rdy[idx] = 1'b1;
                #1;
                d   = r_ph[pi].mem && r_rdy[idx] && (n >= lat);
                exp = r_ph[pi].base | (d ? r_ph[pi].extra : 19'd0);
                chk($sformatf("d%0d op%02h ph%0d cyc%0d state", idx, op, pi, n), 32'(w_st[idx]), 32'(r_ph[pi].st));
                chk($sformatf("d%0d op%02h ph%0d cyc%0d ctrl", idx, op, pi, n), 32'(w_cw[idx]), 32'(exp));
                fin = r_ph[pi].mem ? d : (n >= r_ph[pi].reps);
            end
        end
    endtask

    // Three cycles of reset with mem_ready high; controller must sit idle
    task automatic do_reset(input int idx);
        @(negedge clk);
        r_rstn[idx] = 1'b0;
        r_rdy[idx]  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk($sformatf("d%0d reset state", idx), 32'(w_st[idx]), 32'(S_RST));
            chk($sformatf("d%0d reset ctrl", idx),  32'(w_cw[idx]), 32'd0);
        end
        r_rstn[idx] = 1'b1;
    endtask

    initial begin
        logic [5:0] dir [11] = '{6'h23, 6'h2B, 6'h00, 6'h0D, 6'h08, 6'h04,
                                 6'h05, 6'h02, 6'h0C, 6'h0A, 6'h0F};
        for (int i = 0; i < 2; i++) begin
            r_rstn[i] = 1'b0;
            r_opc[i]  = 6'h00;
            r_rdy[i]  = 1'b0;
        end

        // MEM_LAT=1, trapping controller
        do_reset(0);
        foreach (dir[i]) run_instr(0, dir[i], 0, c_NOSTOP);
        repeat (25) run_instr(0, rand_legal(), 1, c_NOSTOP);
        run_instr(0, 6'h23, 0, S_MEMRD);
        do_reset(0);
        run_instr(0, 6'h3F, 1, c_NOSTOP);
        do_reset(0);
        run_instr(0, rand_illegal(), 1, c_NOSTOP);
        do_reset(0);
        run_instr(0, 6'h2B, 1, c_NOSTOP);

        // MEM_LAT=3, undefined opcodes retire as NOPs
        do_reset(1);
        run_instr(1, 6'h2B, 2, c_NOSTOP);
        run_instr(1, 6'h23, 1, c_NOSTOP);
        run_instr(1, 6'h3F, 0, c_NOSTOP);
        repeat (30) run_instr(1, ($urandom_range(0, 3) == 0) ? rand_illegal() : rand_legal(), 1, c_NOSTOP);
        run_instr(1, 6'h23, 1, S_MEMRD);
        do_reset(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
